// File: rtl/ram_sync_param_if.sv
// Bus interface for ram_sync_param: request/handshake, write data and read-return signals.
// Optional parity signals exist only when RAM_SYNC_PARAM_PARITY_EN is defined.
//
// Handshake: a transaction transfers on a rising clk edge where cs && ready are both 1.
// The master holds cs, rws, addr and wdata stable until that edge. cs without ready has
// no effect, and nothing is queued. Read data returns on rdata with a one-cycle rvalid
// strobe in the cycle after the accept edge. rvalid has no back-pressure.
interface ram_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              cs;
  logic              rws;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              clr_req;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
`ifdef RAM_SYNC_PARAM_PARITY_EN
  logic              par_inj;
  logic              par_err;
`endif

  modport master (
    output cs, rws, addr, wdata, clr_req,
`ifdef RAM_SYNC_PARAM_PARITY_EN
    output par_inj, input par_err,
`endif
    input  ready, rdata, rvalid
  );

  modport slave (
    input  cs, rws, addr, wdata, clr_req,
`ifdef RAM_SYNC_PARAM_PARITY_EN
    input  par_inj, output par_err,
`endif
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/ram_sync_param.sv
// ram_sync_param: single-port synchronous RAM with a registered read port and a
// hardware clear sequencer that writes CLEAR_VAL into every word.
// The optional stored parity bit is enabled by defining RAM_SYNC_PARAM_PARITY_EN.
// The state_dbg output is 1 when the FSM is in IDLE and 0 during a clear sweep.
module ram_sync_param #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 10,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_sync_param_if.slave       bus,
  output logic                  state_dbg
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef RAM_SYNC_PARAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [MEM_W-1:0]  mem [DEPTH];

  logic              ready_int;
  logic              rd_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wword;
  logic [MEM_W-1:0]  rd_word;

  // State register; the array itself is deliberately left out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  // Next state: the sweep ends after the last address is written; clr_req starts one from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (&cnt)       state_nxt = S_IDLE;
      S_IDLE:  if (bus.clr_req) state_nxt = S_CLEAR;
      default:                 state_nxt = RST_STATE;
    endcase
  end

  // Outputs and write-port mux: the clear sequencer owns the write port in CLEAR.
  always_comb begin
    ready_int = (state == S_IDLE);
    rd_acc    = ready_int && bus.cs && !bus.rws;
    mem_we    = 1'b0;
    mem_waddr = bus.addr;
`ifdef RAM_SYNC_PARAM_PARITY_EN
    mem_wword = {(^bus.wdata) ^ bus.par_inj, bus.wdata};
`else
    mem_wword = bus.wdata;
`endif
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt;
`ifdef RAM_SYNC_PARAM_PARITY_EN
      mem_wword = {^CLEAR_VAL, CLEAR_VAL};
`else
      mem_wword = CLEAR_VAL;
`endif
    end else if (bus.cs && bus.rws) begin
      mem_we    = 1'b1;
    end
  end

  assign bus.ready = ready_int;
  assign state_dbg = (state == S_IDLE);

  // Sweep counter: advances every CLEAR cycle (wrapping to 0 at the end), zeroed when a clear starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (state == S_CLEAR) cnt <= cnt + 1'b1;
    else if (bus.clr_req)      cnt <= '0;
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wword;
  end

  // Word addressed by the current request, feeding the registered read port.
  always_comb begin
    rd_word = mem[bus.addr];
  end

  // Registered read data; rdata holds between reads, rvalid pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      bus.rvalid <= rd_acc;
      if (rd_acc) bus.rdata <= rd_word[DATA_W-1:0];
    end
  end

`ifdef RAM_SYNC_PARAM_PARITY_EN
  // Parity check registered alongside rdata; forced low when no read returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.par_err <= 1'b0;
    else        bus.par_err <= rd_acc && (rd_word[DATA_W] != (^rd_word[DATA_W-1:0]));
  end
`endif

endmodule

// File: tb/tb_ram_sync_param.sv
// Testbench for ram_sync_param: directed vectors, expected read results queued at issue
// time and checked by an independent monitor when rvalid is seen.
module tb_ram_sync_param;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic state_dbg;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_sync_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_sync_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1), .CLEAR_VAL(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DATA_W:0] exp_q[$];   // {expected par_err, expected rdata}
  int              due_q[$];   // cycle count at which rvalid must appear

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin : monitor
    logic [DATA_W:0] e;
    int              d;
    if (rst_n && bus.rvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("rdata", 32'(bus.rdata), 32'(e[DATA_W-1:0]));
        check("rvalid_latency", cyc, d);
`ifdef RAM_SYNC_PARAM_PARITY_EN
        check("par_err", 32'(bus.par_err), 32'(e[DATA_W]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    bus.cs = 1'b0; bus.rws = 1'b0; bus.addr = '0; bus.wdata = '0; bus.clr_req = 1'b0;
`ifdef RAM_SYNC_PARAM_PARITY_EN
    bus.par_inj = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.cs = 1'b1; bus.rws = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.cs = 1'b0;
  endtask

`ifdef RAM_SYNC_PARAM_PARITY_EN
  task automatic do_write_inj(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic inj);
    bus.par_inj = inj;
    do_write(a, d);
    bus.par_inj = 1'b0;
  endtask
`endif

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp_d,
                         input logic exp_p, input logic with_clr);
    exp_q.push_back({exp_p, exp_d});
    due_q.push_back(cyc + 1);
    bus.cs = 1'b1; bus.rws = 1'b0; bus.addr = a; bus.clr_req = with_clr;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.clr_req = 1'b0;
  endtask

  // Counts edges until ready is seen high; drops cs at edge count drop_at.
  task automatic wait_ready(input string nm, input int drop_at);
    int  n;
    bit  done;
    n = 0; done = 0;
    while (!done) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == drop_at) bus.cs = 1'b0;
      if (bus.ready || n >= 2000) done = 1;
    end
    check(nm, n, DEPTH);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_bus();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready",     32'(bus.ready),  32'd0);
    check("reset_rvalid",    32'(bus.rvalid), 32'd0);
    check("reset_rdata",     32'(bus.rdata),  32'd0);
    check("reset_state_dbg", 32'(state_dbg),  32'd0);

    // Write request held through the reset sweep must be ignored.
    bus.cs = 1'b1; bus.rws = 1'b1; bus.addr = 10'd5; bus.wdata = 8'hFF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("reset_sweep_len", 1000);
    check("idle_state_dbg", 32'(state_dbg), 32'd1);
    do_read(10'h3FF, 8'h00, 1'b0, 1'b0);
    do_read(10'd5,   8'h00, 1'b0, 1'b0);
    idle(2);

    // Read directly after a write to the same address.
    do_write(10'h155, 8'hA5);
    do_read(10'h155, 8'hA5, 1'b0, 1'b0);
    idle(3);

    // Back-to-back writes then back-to-back reads.
    for (int i = 0; i < 4; i++) do_write(10'(i), 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) do_read(10'(i), 8'(8'h10 + i), 1'b0, 1'b0);
    idle(3);

    // Read accepted together with clr_req still returns the old data, then the sweep runs.
    do_write(10'h200, 8'h77);
    do_read(10'h200, 8'h77, 1'b0, 1'b1);
    @(negedge clk);
    check("clr_ready_drop", 32'(bus.ready), 32'd0);
    wait_ready("clr_sweep_len", -1);
    do_read(10'h200, 8'h00, 1'b0, 1'b0);
    do_read(10'h155, 8'h00, 1'b0, 1'b0);
    idle(2);

    // Reset in the middle of a sweep restarts the full sweep.
    do_write(10'h200, 8'h77);
    bus.clr_req = 1'b1;
    @(posedge clk); #1;
    bus.clr_req = 1'b0;
    repeat (500) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midsweep_rst_ready",  32'(bus.ready),  32'd0);
    check("midsweep_rst_rvalid", 32'(bus.rvalid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready("restart_sweep_len", -1);
    do_read(10'h200, 8'h00, 1'b0, 1'b0);
    do_read(10'd3,   8'h00, 1'b0, 1'b0);
    idle(2);

`ifdef RAM_SYNC_PARAM_PARITY_EN
    do_write_inj(10'd7, 8'h3C, 1'b1);
    do_write_inj(10'd8, 8'h3C, 1'b0);
    do_read(10'd7, 8'h3C, 1'b1, 1'b0);
    do_read(10'd8, 8'h3C, 1'b0, 1'b0);
    idle(2);
`endif

    idle(4);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
